conv_row_feeder: RTL and testbench
==================================

Name: conv_row_feeder

Overview:
Producer-side controller for the convolution kernel loop.
- Loads kx*kx weights from a weight stream and presents them as a held array with weight_ready.
- Assembles one zero-padded pixel row from a pixel stream and holds it with pixel_ready until the loop reports kernel_loop_done.
- Captures the loop's accumulator_out into a result register with a valid/ready output, then pulses MAC_clear.

Parameters:
kx, 3, kernel width/height (odd); pad per side = kx/2
Pix, 3, output pixels per row; padded row width PADW = Pix+2*(kx/2)
RES, 8, data width of pixels, weights and accumulators

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
w_valid  in  1  weight word valid
w_data  in  RES  weight word, row-major kernel order
w_ready  out  1  weight word accepted when w_valid&w_ready
weight_reload  in  1  pulse; request new weight set
s_pix_valid  in  1  pixel word valid
s_pix_data  in  RES  pixel word, left to right
s_pix_ready  out  1  pixel accepted when s_pix_valid&s_pix_ready
weights  out  RES x kx*kx  held weight array
weight_ready  out  1  weight array complete and stable
pixel_row  out  RES x PADW  held padded row
pixel_ready  out  1  pixel_row complete and stable
MAC_clear  out  1  one-cycle accumulator clear
kernel_loop_done  in  1  loop finished current row; accumulator_out final this cycle
accumulator_out  in  RES x Pix  loop accumulators
result  out  RES x Pix  captured row result
result_valid  out  1  result held until result_ready
result_ready  in  1  downstream accepts result

Behaviour:
- Reset:
  - State W_LOAD; widx = fill_cnt = 0.
  - weights, pixel_row and result all zero.
  - weight_ready, pixel_ready, MAC_clear and result_valid all 0.
- w_ready = (state==W_LOAD). s_pix_ready = (state==FILL && fill_cnt<Pix). Both are combinational from registered state; all other outputs are registered.
- W_LOAD:
  - Each accepted weight writes weights[widx], then widx++.
  - On accepting index kx*kx-1: widx<=0, weight_ready<=1, go FILL. weight_ready rises the cycle after the last weight.
- FILL:
  - Each accepted pixel writes pixel_row[kx/2+fill_cnt], then fill_cnt++.
  - Pad entries [0..kx/2-1] and [PADW-kx/2..PADW-1] are constant zero and never written.
  - When fill_cnt==Pix and (result_valid==0 or result_ready==1): pixel_ready<=1, fill_cnt<=0, go ISSUE. Otherwise stay in FILL (output backpressure).
  - weight_reload, sampled only in FILL with fill_cnt==0: weight_ready<=0, go W_LOAD. Ignored in all other states and cycles.
- ISSUE:
  - pixel_row and weights must not change; no stream accepts.
  - On kernel_loop_done==1: result<=accumulator_out, result_valid<=1, pixel_ready<=0, MAC_clear<=1, go CLEAR.
- CLEAR: MAC_clear<=0 (exactly one cycle high); go FILL.
- Result handshake:
  - result_valid clears on result_valid&result_ready.
  - A capture in the same cycle as an accept overrides, so result_valid stays 1 with the new data.
- kernel_loop_done outside ISSUE is ignored.
- weight_reload together with s_pix_valid at fill_cnt==0: reload wins; the pixel is not accepted (s_pix_ready forced 0 that cycle).
- Reset mid-operation: return to reset values immediately; a partial weight set or row is discarded.
- Latency:
  - Last pixel accept to pixel_ready = 1 cycle (when not backpressured).
  - kernel_loop_done to result_valid/MAC_clear = 1 cycle.
  - Minimum row period = Pix + 2 cycles + loop time.

Decomposition:
- Shared package conv_pkg:
  - feeder_state_t enum {W_LOAD, FILL, ISSUE, CLEAR}.
  - Function/localparam PADW(Pix,kx) = Pix+2*(kx/2), shared with the loop.
- Counter widths: widx is $clog2(kx*kx+1); fill_cnt is $clog2(Pix+1).
- Sub-module: reuse GenericCounter for widx (COUNTER_SIZE kx*kx) and for fill_cnt (COUNTER_SIZE Pix). No new sub-module.

Test Plan (Pix=3, kx=3, RES=8):
- After reset, stream weights 1..9 back-to-back -> weights={1..9}; weight_ready=1 the cycle after the 9th accept; w_ready=0 thereafter.
- Stream pixels 10,20,30 -> pixel_row={0,10,20,30,0}; pixel_ready=1 one cycle after 30 is accepted; s_pix_ready=0 during ISSUE.
- In ISSUE, drive kernel_loop_done with accumulator_out={5,6,7} -> next cycle result={5,6,7}, result_valid=1, pixel_ready=0, MAC_clear high for exactly 1 cycle.
- Hold result_ready=0, fill the next row 1,2,3 -> stays in FILL with pixel_ready=0; raise result_ready -> result_valid falls, pixel_ready rises next cycle with {0,1,2,3,0}.
- Pulse weight_reload in FILL at fill_cnt==0 -> weight_ready=0, w_ready=1; load 9,8..1 -> weights updated. A pulse during ISSUE has no effect.
- Assert rst_n=0 mid-ISSUE -> all outputs zero immediately; state W_LOAD, w_ready=1 after release.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution row feeder and the kernel loop it drives.
package conv_pkg;

   typedef enum logic [1:0] {W_LOAD, FILL, ISSUE, CLEAR} feeder_state_t;

   // Padded row width: Pix output pixels plus kx/2 zero columns on each side.
   function automatic int padw(input int pix, input int k);
      return pix + 2 * (k / 2);
   endfunction

endpackage

// File: rtl/GenericCounter.sv
// Up-counter with synchronous clear (clear has priority over increment).
module GenericCounter #(
   parameter  int COUNTER_SIZE = 9,
   localparam int CW           = $clog2(COUNTER_SIZE + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          inc,
   output logic [CW-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc) begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/conv_row_feeder.sv
// Producer-side controller for the convolution kernel loop: loads weights,
// assembles a zero-padded pixel row, captures the loop result and clears the MACs.
module conv_row_feeder
   import conv_pkg::*;
#(
   parameter  int kx   = 3,
   parameter  int Pix  = 3,
   parameter  int RES  = 8,
   localparam int PADW = padw(Pix, kx)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           w_valid,
   input  logic [RES-1:0]                 w_data,
   output logic                           w_ready,
   input  logic                           weight_reload,
   input  logic                           s_pix_valid,
   input  logic [RES-1:0]                 s_pix_data,
   output logic                           s_pix_ready,
   output logic [kx*kx-1:0][RES-1:0]      weights,
   output logic                           weight_ready,
   output logic [PADW-1:0][RES-1:0]       pixel_row,
   output logic                           pixel_ready,
   output logic                           MAC_clear,
   input  logic                           kernel_loop_done,
   input  logic [Pix-1:0][RES-1:0]        accumulator_out,
   output logic [Pix-1:0][RES-1:0]        result,
   output logic                           result_valid,
   input  logic                           result_ready
);

   localparam int NW  = kx * kx;
   localparam int WW  = $clog2(NW + 1);
   localparam int FW  = $clog2(Pix + 1);
   localparam int PAD = kx / 2;
   localparam logic [WW-1:0] W_LAST = WW'(NW - 1);
   localparam logic [FW-1:0] F_FULL = FW'(Pix);

   feeder_state_t             state;
   logic [WW-1:0]             widx;
   logic [FW-1:0]             fill_cnt;
   logic [Pix-1:0][RES-1:0]   row_q;
   logic                      w_accept;
   logic                      w_last;
   logic                      pix_accept;
   logic                      reload_take;
   logic                      row_go;

   assign w_ready     = (state == W_LOAD);
   assign reload_take = (state == FILL) && (fill_cnt == '0) && weight_reload;
   // A reload at an empty row beats a simultaneous pixel.
   assign s_pix_ready = (state == FILL) && (fill_cnt < F_FULL) && !reload_take;
   assign w_accept    = w_valid && w_ready;
   assign w_last      = w_accept && (widx == W_LAST);
   assign pix_accept  = s_pix_valid && s_pix_ready;
   assign row_go      = (state == FILL) && (fill_cnt == F_FULL) &&
                        (!result_valid || result_ready);

   GenericCounter #(.COUNTER_SIZE(NW)) u_widx (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (w_last),
      .inc   (w_accept),
      .count (widx)
   );

   GenericCounter #(.COUNTER_SIZE(Pix)) u_fill (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (row_go),
      .inc   (pix_accept),
      .count (fill_cnt)
   );

   // Pad columns are constant zero; only the interior is stored.
   always_comb begin
      pixel_row = '0;
      for (int i = 0; i < Pix; i++) begin
         pixel_row[PAD+i] = row_q[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= W_LOAD;
         weights      <= '0;
         row_q        <= '0;
         result       <= '0;
         weight_ready <= 1'b0;
         pixel_ready  <= 1'b0;
         MAC_clear    <= 1'b0;
         result_valid <= 1'b0;
      end else begin
         // A capture later in this block overrides a same-cycle accept.
         if (result_valid && result_ready) begin
            result_valid <= 1'b0;
         end
         case (state)
            W_LOAD: begin
               if (w_accept) begin
                  weights[widx] <= w_data;
                  if (w_last) begin
                     weight_ready <= 1'b1;
                     state        <= FILL;
                  end
               end
            end
            FILL: begin
               if (reload_take) begin
                  weight_ready <= 1'b0;
                  state        <= W_LOAD;
               end else begin
                  if (pix_accept) begin
                     row_q[fill_cnt] <= s_pix_data;
                  end
                  if (row_go) begin
                     pixel_ready <= 1'b1;
                     state       <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (kernel_loop_done) begin
                  result       <= accumulator_out;
                  result_valid <= 1'b1;
                  pixel_ready  <= 1'b0;
                  MAC_clear    <= 1'b1;
                  state        <= CLEAR;
               end
            end
            CLEAR: begin
               MAC_clear <= 1'b0;
               state     <= FILL;
            end
            default: state <= W_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_row_feeder.sv
// Self-checking bench for conv_row_feeder: directed plan plus randomized traffic
// compared every cycle against a behavioural model of the feeder.
module tb_conv_row_feeder;

   localparam int KX   = 3;
   localparam int PIX  = 3;
   localparam int RES  = 8;
   localparam int PADW = PIX + 2 * (KX / 2);
   localparam int NW   = KX * KX;
   localparam int PAD  = KX / 2;

   logic                        clk = 1'b0;
   logic                        rst_n;
   logic                        w_valid;
   logic [RES-1:0]              w_data;
   logic                        w_ready;
   logic                        weight_reload;
   logic                        s_pix_valid;
   logic [RES-1:0]              s_pix_data;
   logic                        s_pix_ready;
   logic [NW-1:0][RES-1:0]      weights;
   logic                        weight_ready;
   logic [PADW-1:0][RES-1:0]    pixel_row;
   logic                        pixel_ready;
   logic                        MAC_clear;
   logic                        kernel_loop_done;
   logic [PIX-1:0][RES-1:0]     accumulator_out;
   logic [PIX-1:0][RES-1:0]     result;
   logic                        result_valid;
   logic                        result_ready;

   always #5 clk = ~clk;

   conv_row_feeder #(.kx(KX), .Pix(PIX), .RES(RES)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .w_valid          (w_valid),
      .w_data           (w_data),
      .w_ready          (w_ready),
      .weight_reload    (weight_reload),
      .s_pix_valid      (s_pix_valid),
      .s_pix_data       (s_pix_data),
      .s_pix_ready      (s_pix_ready),
      .weights          (weights),
      .weight_ready     (weight_ready),
      .pixel_row        (pixel_row),
      .pixel_ready      (pixel_ready),
      .MAC_clear        (MAC_clear),
      .kernel_loop_done (kernel_loop_done),
      .accumulator_out  (accumulator_out),
      .result           (result),
      .result_valid     (result_valid),
      .result_ready     (result_ready)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: what phase the feeder is in, and what it holds.
   int             m_phase;        // 0 loading weights, 1 collecting row, 2 waiting on loop, 3 clear pulse
   int             m_wn, m_pn;
   logic [RES-1:0] m_w   [NW];
   logic [RES-1:0] m_row [PIX];
   logic [RES-1:0] m_res [PIX];
   logic           m_wrdy, m_prdy, m_clr, m_rv;

   task automatic model_reset();
      m_phase = 0; m_wn = 0; m_pn = 0;
      m_wrdy = 0; m_prdy = 0; m_clr = 0; m_rv = 0;
      for (int i = 0; i < NW; i++) m_w[i] = '0;
      for (int i = 0; i < PIX; i++) begin m_row[i] = '0; m_res[i] = '0; end
   endtask

   task automatic model_step();
      logic rv_next;
      rv_next = (m_rv && result_ready) ? 1'b0 : m_rv;
      if (m_phase == 0) begin
         if (w_valid) begin
            m_w[m_wn] = w_data;
            m_wn++;
            if (m_wn == NW) begin m_wn = 0; m_wrdy = 1; m_phase = 1; end
         end
      end else if (m_phase == 1) begin
         if (m_pn == 0 && weight_reload) begin
            m_wrdy = 0; m_phase = 0;
         end else if (m_pn < PIX) begin
            if (s_pix_valid) begin m_row[m_pn] = s_pix_data; m_pn++; end
         end else if (!m_rv || result_ready) begin
            m_prdy = 1; m_pn = 0; m_phase = 2;
         end
      end else if (m_phase == 2) begin
         if (kernel_loop_done) begin
            for (int i = 0; i < PIX; i++) m_res[i] = accumulator_out[i];
            rv_next = 1; m_prdy = 0; m_clr = 1; m_phase = 3;
         end
      end else begin
         m_clr = 0; m_phase = 1;
      end
      m_rv = rv_next;
   endtask

   task automatic check_ready();
      chk("w_ready", w_ready, m_phase == 0);
      chk("s_pix_ready", s_pix_ready,
          (m_phase == 1) && (m_pn < PIX) && !(m_pn == 0 && weight_reload));
   endtask

   task automatic check_regs();
      for (int i = 0; i < NW; i++) chk("weights", weights[i], m_w[i]);
      for (int i = 0; i < PAD; i++) begin
         chk("pad_left", pixel_row[i], 0);
         chk("pad_right", pixel_row[PADW-1-i], 0);
      end
      for (int i = 0; i < PIX; i++) begin
         chk("pixel_row", pixel_row[PAD+i], m_row[i]);
         chk("result", result[i], m_res[i]);
      end
      chk("weight_ready", weight_ready, m_wrdy);
      chk("pixel_ready", pixel_ready, m_prdy);
      chk("MAC_clear", MAC_clear, m_clr);
      chk("result_valid", result_valid, m_rv);
   endtask

   // Inputs are set by the caller before tick and held across the edge.
   task automatic tick();
      #1;
      check_ready();
      @(posedge clk);
      if (!rst_n) model_reset(); else model_step();
      @(negedge clk);
      check_regs();
   endtask

   task automatic idle_inputs();
      w_valid = 0; w_data = '0; weight_reload = 0; s_pix_valid = 0; s_pix_data = '0;
      kernel_loop_done = 0; accumulator_out = '0;
   endtask

   initial begin
      rst_n = 0; result_ready = 0;
      idle_inputs();
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_weight_ready", weight_ready, 0);
      chk("rst_result_valid", result_valid, 0);
      check_regs();
      rst_n = 1;

      // Weights 1..9 back to back.
      for (int i = 1; i <= NW; i++) begin
         w_valid = 1; w_data = RES'(i);
         tick();
      end
      w_valid = 0;
      chk("lit_weight_ready_after_9", weight_ready, 1);
      for (int i = 0; i < NW; i++) chk("lit_weights_1to9", weights[i], i + 1);
      chk("lit_w_ready_low", w_ready, 0);

      // Row 10,20,30.
      for (int i = 1; i <= PIX; i++) begin
         s_pix_valid = 1; s_pix_data = RES'(10 * i);
         tick();
      end
      s_pix_valid = 0;
      tick();
      chk("lit_pixel_ready", pixel_ready, 1);
      chk("lit_row0", pixel_row[0], 0);
      chk("lit_row1", pixel_row[1], 10);
      chk("lit_row2", pixel_row[2], 20);
      chk("lit_row3", pixel_row[3], 30);
      chk("lit_row4", pixel_row[4], 0);
      chk("lit_s_pix_ready_issue", s_pix_ready, 0);

      // Reload during ISSUE is ignored.
      weight_reload = 1;
      tick();
      weight_reload = 0;
      chk("lit_reload_issue_ignored", weight_ready, 1);

      kernel_loop_done = 1;
      accumulator_out[0] = 8'd5; accumulator_out[1] = 8'd6; accumulator_out[2] = 8'd7;
      tick();
      kernel_loop_done = 0;
      chk("lit_result0", result[0], 5);
      chk("lit_result1", result[1], 6);
      chk("lit_result2", result[2], 7);
      chk("lit_result_valid", result_valid, 1);
      chk("lit_pixel_ready_drop", pixel_ready, 0);
      chk("lit_mac_clear_hi", MAC_clear, 1);
      tick();
      chk("lit_mac_clear_lo", MAC_clear, 0);

      // Backpressure: next row held in FILL until result accepted.
      for (int i = 1; i <= PIX; i++) begin
         s_pix_valid = 1; s_pix_data = RES'(i);
         tick();
      end
      s_pix_valid = 0;
      tick(); tick();
      chk("lit_bp_pixel_ready", pixel_ready, 0);
      chk("lit_bp_result_valid", result_valid, 1);
      result_ready = 1;
      tick();
      chk("lit_bp_rv_fall", result_valid, 0);
      chk("lit_bp_pixel_ready_rise", pixel_ready, 1);
      chk("lit_bp_row2", pixel_row[2], 2);
      chk("lit_bp_row3", pixel_row[3], 3);

      kernel_loop_done = 1;
      accumulator_out[0] = 8'd1; accumulator_out[1] = 8'd2; accumulator_out[2] = 8'd3;
      tick();
      kernel_loop_done = 0;
      tick();

      // Reload at empty row beats a simultaneous pixel.
      weight_reload = 1; s_pix_valid = 1; s_pix_data = 8'd99;
      #1 chk("lit_reload_blocks_pixel", s_pix_ready, 0);
      tick();
      weight_reload = 0; s_pix_valid = 0;
      chk("lit_reload_weight_ready", weight_ready, 0);
      #1 chk("lit_reload_w_ready", w_ready, 1);
      for (int i = 0; i < NW; i++) begin
         w_valid = 1; w_data = RES'(NW - i);
         tick();
      end
      w_valid = 0;
      for (int i = 0; i < NW; i++) chk("lit_weights_9to1", weights[i], NW - i);
      for (int i = 0; i < PIX; i++) begin
         s_pix_valid = 1; s_pix_data = RES'(4 + i);
         tick();
      end
      s_pix_valid = 0;
      tick();
      chk("lit_row_after_reload", pixel_row[1], 4);
      chk("lit_pixel_ready_2", pixel_ready, 1);

      // Reset in ISSUE clears everything immediately.
      rst_n = 0;
      #1;
      chk("lit_arst_weight_ready", weight_ready, 0);
      chk("lit_arst_pixel_ready", pixel_ready, 0);
      chk("lit_arst_weights0", weights[0], 0);
      chk("lit_arst_row1", pixel_row[1], 0);
      chk("lit_arst_result0", result[0], 0);
      chk("lit_arst_result_valid", result_valid, 0);
      model_reset();
      tick();
      rst_n = 1;
      #1 chk("lit_post_rst_w_ready", w_ready, 1);

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         w_valid          = ($urandom_range(0, 3) != 0);
         w_data           = RES'($urandom);
         weight_reload    = ($urandom_range(0, 15) == 0);
         s_pix_valid      = ($urandom_range(0, 3) != 0);
         s_pix_data       = RES'($urandom);
         kernel_loop_done = ($urandom_range(0, 3) == 0);
         accumulator_out  = (PIX * RES)'($urandom);
         result_ready     = ($urandom_range(0, 1) == 1);
         if (c == 1500) begin
            rst_n = 0;
            model_reset();
         end else begin
            rst_n = 1;
         end
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
